serial_adder: RTL



---
 rtl/serial_adder_pkg.sv | 22 ++
 rtl/full_adder.sv | 16 +
 rtl/serial_adder.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
//   state_e : controller states (IDLE, RUN, DONE)
//   clog2   : ceiling log2, used to size the bit counter
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Ceiling log2; returns 0 for n <= 1, callers clamp to a minimum width.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage : serial_adder_pkg

// File: rtl/full_adder.sv
// Single-bit full adder cell.
//   a, b, cin : addend bits and carry-in
//   sum       : a ^ b ^ cin
//   carry     : carry-out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (cin & (a ^ b));

endmodule : full_adder

// File: rtl/serial_adder.sv
// Bit-serial adder: {carry,sum} = a + b + cin, one bit per clock, LSB first.
// A single full_adder is fed from operand shift registers; the inter-bit
// carry lives in a flop. Result appears WIDTH+1 cycles after an accepted start.
//   clk, rst    : clock, asynchronous active-high reset
//   start       : accept operands when idle or in the done cycle
//   a, b, cin   : operands, sampled only on an accepted start
//   busy        : high while bits are being processed
//   done        : one-cycle pulse when sum/carry are updated
//   sum, carry  : registered result, held until the next completion
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int unsigned CNT_W = (clog2(WIDTH) == 0) ? 1 : clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] s_sh_q, s_sh_d;
  logic             c_q, c_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;

  logic             fa_s;
  logic             fa_co;
  logic             accept_c;
  logic             last_c;

  // Operand LSBs and the running carry feed the one adder cell.
  full_adder u_fa (
    .a     (a_sh_q[0]),
    .b     (b_sh_q[0]),
    .cin   (c_q),
    .sum   (fa_s),
    .carry (fa_co)
  );

  // start is honoured only when no addition is in flight.
  assign accept_c = start && ((state_q == IDLE) || (state_q == DONE));
  assign last_c   = (state_q == RUN) && (cnt_q == CNT_LAST);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_c) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values; busy/done are registered from state_d
  // so they line up exactly with the state they report.
  always_comb begin
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    busy_d  = (state_d == RUN);
    done_d  = (state_d == DONE);

    if (accept_c) begin
      a_sh_d = a;
      b_sh_d = b;
      c_d    = cin;
      cnt_d  = '0;
    end else if (state_q == RUN) begin
      a_sh_d = a_sh_q >> 1;
      b_sh_d = b_sh_q >> 1;
      // New sum bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
      s_sh_d            = s_sh_q >> 1;
      s_sh_d[WIDTH-1]   = fa_s;
      c_d               = fa_co;
      cnt_d             = cnt_q + 1'b1;
      if (last_c) begin
        sum_d   = s_sh_d;
        carry_d = fa_co;
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign carry = carry_q;

endmodule : serial_adder
